alarm_set_ctrl: RTL and testbench
=================================

Name: alarm_set_ctrl

Overview:
Front-panel controller that sequences time and alarm setting for the alarm clock. It turns three debounced button levels into single-cycle press events through internal rising-edge detectors, then steps a mode FSM through hour/minute fields. It edits a working value with wrap-around and commits it either to the timekeeper through a load strobe or to the held alarm registers. It sits between the button debouncers and the timekeeper/alarm-compare datapath.

Parameters:
TIMEOUT_CYCLES, 32'd1_000_000_000, idle cycles in any SET state before abort to RUN (10 s at 100 MHz)
HOLD_CYCLES, 32'd50_000_000, hold time before auto-repeat starts (AUTOREPEAT_EN only)
REPEAT_CYCLES, 32'd20_000_000, auto-repeat period (AUTOREPEAT_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
btn_mode  in  1  debounced mode button level
btn_inc  in  1  debounced increment button level
btn_dec  in  1  debounced decrement button level
cur_hour  in  5  timekeeper hour, 0..23
cur_min  in  6  timekeeper minute, 0..59
time_load  out  1  one-cycle strobe: timekeeper loads load_hour/load_min, seconds cleared
load_hour  out  5  hour value to load
load_min  out  6  minute value to load
alarm_hour  out  5  committed alarm hour
alarm_min  out  6  committed alarm minute
alarm_en  out  1  alarm armed
edit_active  out  1  high in any SET state
edit_field  out  2  0=none, 1=hour, 2=minute (display blink select)
edit_is_alarm  out  1  high in SET_AHR/SET_AMIN
edit_value  out  6  working value shown on the display while editing

Behaviour:
- Reset (rst_n=0 at posedge clk): state RUN, all outputs 0, edit regs 0, edge-detector history 0, timeout counter 0.
- Press events: mode_p/inc_p/dec_p assert for exactly one cycle, in the cycle after the first clk at which the level is sampled high. A held level gives no further events. A level high out of reset gives one event, one cycle after the first high sample.
- Priority in one cycle: mode_p over inc_p/dec_p. When inc_p and dec_p are both set, edit_value does not change.
- States and transitions (all on press events):
  RUN --mode_p--> SET_HR; edit_hr<=cur_hour, edit_mn<=cur_min.
  SET_HR --mode_p--> SET_MIN.
  SET_MIN --mode_p--> SET_AHR; time_load=1 for this cycle with load_hour=edit_hr, load_min=edit_mn; edit_hr<=alarm_hour, edit_mn<=alarm_min.
  SET_AHR --mode_p--> SET_AMIN.
  SET_AMIN --mode_p--> RUN; alarm_hour<=edit_hr, alarm_min<=edit_mn, alarm_en<=1.
- In RUN: inc_p toggles alarm_en. dec_p is ignored.
- Editing: inc_p/dec_p change the active field. Hour wraps 23->0 and 0->23; minute wraps 59->0 and 0->59. The other field is untouched.
- load_hour/load_min are registered and hold their last value between strobes. time_load is never high two cycles in a row.
- Timeout: the counter clears on any press event and on state entry, and increments each cycle in SET states. On reaching TIMEOUT_CYCLES-1 the FSM goes to RUN with no load or alarm commit; time committed earlier in the same pass is kept.
- edit_value = edit_hr zero-extended when edit_field=1, edit_mn when edit_field=2, else 0.
- Mid-operation reset returns to RUN, discards edits and clears alarm_en and the alarm registers.

Optional Feature:
ALARM_SET_AUTOREPEAT_EN
- Defined: in SET states, if btn_inc or btn_dec is held after its press event, a hold counter reaches HOLD_CYCLES, then generates a synthetic inc/dec event every REPEAT_CYCLES until release. Synthetic events also clear the timeout. If both buttons are held, no repeat occurs.
- Undefined: hold and repeat logic is absent; only edge events change values.

Decomposition:
- Package alarm_set_pkg: state enum (RUN, SET_HR, SET_MIN, SET_AHR, SET_AMIN, 3-bit encoding), edit_field codes, HOUR_MAX=23, MIN_MAX=59, field widths.
- Sub-module btn_rise: per-button registered rising-edge pulse generator with clk, rst_n, level in and pulse out; instantiated three times.

Test Plan:
- Reset then btn_mode high 5 cycles -> state SET_HR; edit_field=1; edit_value=cur_hour (e.g. 14); exactly one mode event.
- In SET_HR with edit_hr=23, one btn_inc press -> edit_value=0. In SET_MIN with edit_mn=0, one btn_dec press -> edit_value=59.
- Full pass: cur 14:30, set hour 15 and min 45, mode -> time_load one cycle with load 15/45; set alarm 06:00, mode -> alarm_hour=6, alarm_min=0, alarm_en=1, state RUN.
- btn_inc and btn_dec rising in the same cycle during SET_MIN -> edit_value unchanged. btn_mode and btn_inc together -> only the state advances.
- TIMEOUT_CYCLES=100, enter SET_AHR and idle 100 cycles -> state RUN, alarm registers unchanged, no time_load.
- rst_n=0 for one cycle during SET_MIN -> all outputs 0 and state RUN on the next cycle. With ALARM_SET_AUTOREPEAT_EN, HOLD=10, REPEAT=4, hold btn_inc 30 cycles -> 1+5 increments.

Source files
------------

// File: rtl/alarm_set_pkg.sv
// Shared state/field encodings and wrap-around step helpers for alarm_set_ctrl.
package alarm_set_pkg;
  localparam int HR_W = 5;
  localparam int MN_W = 6;

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_SET_HR   = 3'd1;
  localparam logic [2:0] ST_SET_MIN  = 3'd2;
  localparam logic [2:0] ST_SET_AHR  = 3'd3;
  localparam logic [2:0] ST_SET_AMIN = 3'd4;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;

  localparam logic [HR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MN_W-1:0] MIN_MAX  = 6'd59;

  function automatic logic [HR_W-1:0] hour_step(input logic [HR_W-1:0] h, input logic up);
    if (up) return (h == HOUR_MAX) ? 5'd0 : h + 5'd1;
    return (h == 5'd0) ? HOUR_MAX : h - 5'd1;
  endfunction

  function automatic logic [MN_W-1:0] min_step(input logic [MN_W-1:0] m, input logic up);
    if (up) return (m == MIN_MAX) ? 6'd0 : m + 6'd1;
    return (m == 6'd0) ? MIN_MAX : m - 6'd1;
  endfunction
endpackage

// File: rtl/btn_rise.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a level is first sampled high.
module btn_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);
  logic prev_q, pulse_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      pulse_q <= level_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/alarm_set_ctrl.sv
// Front-panel mode FSM for time/alarm setting with idle timeout.
// Optional hold-to-repeat on inc/dec when ALARM_SET_AUTOREPEAT_EN is defined.
module alarm_set_ctrl
  import alarm_set_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000,
  parameter logic [31:0] HOLD_CYCLES    = 32'd50_000_000,
  parameter logic [31:0] REPEAT_CYCLES  = 32'd20_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_mode,
  input  logic            btn_inc,
  input  logic            btn_dec,
  input  logic [HR_W-1:0] cur_hour,
  input  logic [MN_W-1:0] cur_min,
  output logic            time_load,
  output logic [HR_W-1:0] load_hour,
  output logic [MN_W-1:0] load_min,
  output logic [HR_W-1:0] alarm_hour,
  output logic [MN_W-1:0] alarm_min,
  output logic            alarm_en,
  output logic            edit_active,
  output logic [1:0]      edit_field,
  output logic            edit_is_alarm,
  output logic [MN_W-1:0] edit_value
);
  logic mode_p, inc_raw_p, dec_raw_p, inc_p, dec_p;

  btn_rise u_mode (.clk(clk), .rst_n(rst_n), .level_i(btn_mode), .pulse_o(mode_p));
  btn_rise u_inc  (.clk(clk), .rst_n(rst_n), .level_i(btn_inc),  .pulse_o(inc_raw_p));
  btn_rise u_dec  (.clk(clk), .rst_n(rst_n), .level_i(btn_dec),  .pulse_o(dec_raw_p));

  logic [2:0]      state_q, state_d;
  logic [HR_W-1:0] edit_hr_q, edit_hr_d, alarm_hr_q, alarm_hr_d, load_hr_q, load_hr_d;
  logic [MN_W-1:0] edit_mn_q, edit_mn_d, alarm_mn_q, alarm_mn_d, load_mn_q, load_mn_d;
  logic            alarm_en_q, alarm_en_d, time_load_q, time_load_d;
  logic [31:0]     to_cnt_q, to_cnt_d;
  logic [1:0]      field;
  logic            in_set;

  assign in_set = (state_q != ST_RUN);

`ifdef ALARM_SET_AUTOREPEAT_EN
  // Hold timer restarts on every real press; phase 0 waits HOLD, phase 1 paces repeats.
  logic [31:0] rep_cnt_q;
  logic        rep_phase_q, rep_inc_q, rep_dec_q, one_held;

  assign one_held = in_set & (btn_inc ^ btn_dec);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
      rep_inc_q   <= 1'b0;
      rep_dec_q   <= 1'b0;
    end else begin
      rep_inc_q <= 1'b0;
      rep_dec_q <= 1'b0;
      if (!one_held || inc_raw_p || dec_raw_p) begin
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b0;
      end else if (rep_cnt_q == (rep_phase_q ? REPEAT_CYCLES - 32'd1 : HOLD_CYCLES - 32'd1)) begin
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b1;
        rep_inc_q   <= btn_inc;
        rep_dec_q   <= btn_dec;
      end else begin
        rep_cnt_q <= rep_cnt_q + 32'd1;
      end
    end
  end

  assign inc_p = inc_raw_p | (rep_inc_q & in_set);
  assign dec_p = dec_raw_p | (rep_dec_q & in_set);
`else
  logic unused_rep_params;
  assign unused_rep_params = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign inc_p = inc_raw_p;
  assign dec_p = dec_raw_p;
`endif

  always_comb begin
    field = FLD_NONE;
    case (state_q)
      ST_SET_HR, ST_SET_AHR:   field = FLD_HOUR;
      ST_SET_MIN, ST_SET_AMIN: field = FLD_MIN;
      default:                 field = FLD_NONE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    edit_hr_d   = edit_hr_q;
    edit_mn_d   = edit_mn_q;
    alarm_hr_d  = alarm_hr_q;
    alarm_mn_d  = alarm_mn_q;
    alarm_en_d  = alarm_en_q;
    load_hr_d   = load_hr_q;
    load_mn_d   = load_mn_q;
    time_load_d = 1'b0;
    to_cnt_d    = to_cnt_q;

    // mode wins over inc/dec in the same cycle
    if (mode_p) begin
      case (state_q)
        ST_RUN: begin
          state_d   = ST_SET_HR;
          edit_hr_d = cur_hour;
          edit_mn_d = cur_min;
        end
        ST_SET_HR:  state_d = ST_SET_MIN;
        ST_SET_MIN: begin
          state_d     = ST_SET_AHR;
          time_load_d = 1'b1;
          load_hr_d   = edit_hr_q;
          load_mn_d   = edit_mn_q;
          edit_hr_d   = alarm_hr_q;
          edit_mn_d   = alarm_mn_q;
        end
        ST_SET_AHR: state_d = ST_SET_AMIN;
        ST_SET_AMIN: begin
          state_d    = ST_RUN;
          alarm_hr_d = edit_hr_q;
          alarm_mn_d = edit_mn_q;
          alarm_en_d = 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end else if (!in_set) begin
      if (inc_p) alarm_en_d = ~alarm_en_q;
    end else if (inc_p ^ dec_p) begin
      if (field == FLD_HOUR)     edit_hr_d = hour_step(edit_hr_q, inc_p);
      else if (field == FLD_MIN) edit_mn_d = min_step(edit_mn_q, inc_p);
    end

    // any event (including the one that entered the state) restarts the idle window
    if (mode_p || inc_p || dec_p || !in_set) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
      to_cnt_d = '0;
      state_d  = ST_RUN;
    end else begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      edit_hr_q   <= '0;
      edit_mn_q   <= '0;
      alarm_hr_q  <= '0;
      alarm_mn_q  <= '0;
      alarm_en_q  <= 1'b0;
      load_hr_q   <= '0;
      load_mn_q   <= '0;
      time_load_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      edit_hr_q   <= edit_hr_d;
      edit_mn_q   <= edit_mn_d;
      alarm_hr_q  <= alarm_hr_d;
      alarm_mn_q  <= alarm_mn_d;
      alarm_en_q  <= alarm_en_d;
      load_hr_q   <= load_hr_d;
      load_mn_q   <= load_mn_d;
      time_load_q <= time_load_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign time_load     = time_load_q;
  assign load_hour     = load_hr_q;
  assign load_min      = load_mn_q;
  assign alarm_hour    = alarm_hr_q;
  assign alarm_min     = alarm_mn_q;
  assign alarm_en      = alarm_en_q;
  assign edit_active   = in_set;
  assign edit_field    = field;
  assign edit_is_alarm = (state_q == ST_SET_AHR) || (state_q == ST_SET_AMIN);
  assign edit_value    = (field == FLD_HOUR) ? {1'b0, edit_hr_q} :
                         (field == FLD_MIN)  ? edit_mn_q : '0;
endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Self-checking bench for alarm_set_ctrl: directed vector table, multi-cycle corner sequences,
// and random button traffic against a cycle-level behavioural model.
module tb_alarm_set_ctrl;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n, btn_mode, btn_inc, btn_dec;
  logic [4:0] cur_hour, load_hour, alarm_hour;
  logic [5:0] cur_min, load_min, alarm_min, edit_value;
  logic       time_load, alarm_en, edit_active, edit_is_alarm;
  logic [1:0] edit_field;

  alarm_set_ctrl #(
    .TIMEOUT_CYCLES(32'd100), .HOLD_CYCLES(32'd10), .REPEAT_CYCLES(32'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hour(cur_hour), .cur_min(cur_min), .time_load(time_load), .load_hour(load_hour),
    .load_min(load_min), .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
    .edit_active(edit_active), .edit_field(edit_field), .edit_is_alarm(edit_is_alarm),
    .edit_value(edit_value)
  );

  always #5 clk = ~clk;

  logic [33:0] dut_vec;
  assign dut_vec = {time_load, load_hour, load_min, alarm_hour, alarm_min, alarm_en,
                    edit_active, edit_field, edit_is_alarm, edit_value};

  int checks = 0, errors = 0, n_load = 0;
  bit mdl_on = 1'b0;

  always @(negedge clk) if (time_load === 1'b1) n_load++;

  // Behavioural model: state 0=RUN,1=set hour,2=set min,3=alarm hour,4=alarm min
  int m_st, m_hr, m_mn, m_ahr, m_amn, m_lhr, m_lmn, m_idle;
  bit m_aen, m_tl, m_evm, m_evi, m_evd, m_lvm, m_lvi, m_lvd;

  always @(posedge clk) begin
    bit em, ei, ed;
    if (!rst_n) begin
      m_st = 0; m_hr = 0; m_mn = 0; m_ahr = 0; m_amn = 0; m_lhr = 0; m_lmn = 0; m_idle = 0;
      m_aen = 0; m_tl = 0; m_evm = 0; m_evi = 0; m_evd = 0; m_lvm = 0; m_lvi = 0; m_lvd = 0;
    end else begin
      em = m_evm; ei = m_evi; ed = m_evd;
      m_evm = btn_mode && !m_lvm; m_evi = btn_inc && !m_lvi; m_evd = btn_dec && !m_lvd;
      m_lvm = btn_mode; m_lvi = btn_inc; m_lvd = btn_dec;
      m_tl = 0;
      if (em) begin
        case (m_st)
          0: begin m_st = 1; m_hr = int'(cur_hour); m_mn = int'(cur_min); end
          1: m_st = 2;
          2: begin m_tl = 1; m_lhr = m_hr; m_lmn = m_mn; m_hr = m_ahr; m_mn = m_amn; m_st = 3; end
          3: m_st = 4;
          default: begin m_ahr = m_hr; m_amn = m_mn; m_aen = 1; m_st = 0; end
        endcase
      end else if (m_st == 0) begin
        if (ei) m_aen = !m_aen;
      end else if (ei != ed) begin
        if (m_st == 1 || m_st == 3) m_hr = ei ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
        else                        m_mn = ei ? (m_mn + 1) % 60 : (m_mn + 59) % 60;
      end
      if (em || ei || ed) m_idle = 0;
      else if (m_st != 0) begin
        if (m_idle == TO - 1) begin m_st = 0; m_idle = 0; end
        else m_idle++;
      end
    end
  end

  function automatic logic [33:0] mdl_vec();
    int f, v;
    f = (m_st == 1 || m_st == 3) ? 1 : (m_st == 2 || m_st == 4) ? 2 : 0;
    v = (f == 1) ? m_hr : (f == 2) ? m_mn : 0;
    return {m_tl, 5'(m_lhr), 6'(m_lmn), 5'(m_ahr), 6'(m_amn), m_aen, (m_st != 0), 2'(f),
            (m_st == 3 || m_st == 4), 6'(v)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mdl_on) chk("model", 64'(dut_vec), 64'(mdl_vec()));
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    {btn_mode, btn_inc, btn_dec} = b;
    repeat (hold) tick();
    {btn_mode, btn_inc, btn_dec} = 3'b000;
    repeat (3) tick();
  endtask

  typedef struct {
    logic [2:0] btn;  int hold;
    logic [4:0] ch;   logic [5:0] cm;
    logic [1:0] f;    logic [5:0] v;
    logic       aen;  logic [4:0] ahr; logic [5:0] amn;
    logic [4:0] lhr;  logic [5:0] lmn; int nl;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [2:0] b, input int h, input logic [4:0] ch, input logic [5:0] cm,
                     input logic [1:0] f, input logic [5:0] v, input logic aen,
                     input logic [4:0] ahr, input logic [5:0] amn,
                     input logic [4:0] lhr, input logic [5:0] lmn, input int nl);
    vec_t r;
    r.btn = b; r.hold = h; r.ch = ch; r.cm = cm; r.f = f; r.v = v; r.aen = aen;
    r.ahr = ahr; r.amn = amn; r.lhr = lhr; r.lmn = lmn; r.nl = nl;
    tbl.push_back(r);
  endtask

  localparam logic [2:0] M = 3'b100, I = 3'b010, D = 3'b001;

  initial begin
    int n;
    rst_n = 1'b0; btn_mode = 0; btn_inc = 0; btn_dec = 0;
    cur_hour = 5'd14; cur_min = 6'd44; mdl_on = 1'b1;

    //   btn   hold ch  cm  f  v   aen ahr amn lhr lmn nload
    add(I,     2, 14, 44, 0, 0,  1, 0, 0,  0,  0,  0);  // RUN inc toggles arm
    add(I,     2, 14, 44, 0, 0,  0, 0, 0,  0,  0,  0);
    add(D,     2, 14, 44, 0, 0,  0, 0, 0,  0,  0,  0);  // RUN dec ignored
    add(M,     5, 14, 44, 1, 14, 0, 0, 0,  0,  0,  0);  // held mode: one event only
    add(I,     2, 14, 44, 1, 15, 0, 0, 0,  0,  0,  0);
    add(M,     2, 14, 44, 2, 44, 0, 0, 0,  0,  0,  0);
    add(I,     2, 14, 44, 2, 45, 0, 0, 0,  0,  0,  0);
    add(M,     2, 14, 44, 1, 0,  0, 0, 0,  15, 45, 1);  // time committed
    for (int k = 1; k <= 6; k++) add(I, 2, 14, 44, 1, 6'(k), 0, 0, 0, 15, 45, 1);
    add(M,     2, 14, 44, 2, 0,  0, 0, 0,  15, 45, 1);
    add(D,     2, 14, 44, 2, 59, 0, 0, 0,  15, 45, 1);  // minute 0 -> 59
    add(I,     2, 14, 44, 2, 0,  0, 0, 0,  15, 45, 1);  // minute 59 -> 0
    add(M,     2, 14, 44, 0, 0,  1, 6, 0,  15, 45, 1);  // alarm committed
    add(M,     2, 23, 0,  1, 23, 1, 6, 0,  15, 45, 1);
    add(I,     2, 23, 0,  1, 0,  1, 6, 0,  15, 45, 1);  // hour 23 -> 0
    add(M,     2, 23, 0,  2, 0,  1, 6, 0,  15, 45, 1);
    add(D,     2, 23, 0,  2, 59, 1, 6, 0,  15, 45, 1);
    add(I | D, 2, 23, 0,  2, 59, 1, 6, 0,  15, 45, 1);  // inc+dec cancel
    add(M | I, 2, 23, 0,  1, 6,  1, 6, 0,  0,  59, 2);  // mode beats inc

    repeat (3) tick();
    chk("reset_outputs", 64'(dut_vec), 64'd0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      cur_hour = tbl[i].ch; cur_min = tbl[i].cm;
      press(tbl[i].btn, tbl[i].hold);
      chk($sformatf("vec%0d_field_value", i), {edit_field, edit_value}, {tbl[i].f, tbl[i].v});
      chk($sformatf("vec%0d_alarm", i), {alarm_en, alarm_hour, alarm_min},
          {tbl[i].aen, tbl[i].ahr, tbl[i].amn});
      chk($sformatf("vec%0d_load", i), {load_hour, load_min}, {tbl[i].lhr, tbl[i].lmn});
      chk($sformatf("vec%0d_load_count", i), n_load, tbl[i].nl);
    end

    // idle timeout from SET_AHR: cycles the controller stays in edit after the last press
    btn_inc = 1'b1; n = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      btn_inc = 1'b0;
      if (edit_active) n++;
      else break;
    end
    chk("timeout_cycles", n, 101);
    chk("timeout_alarm_kept", {alarm_en, alarm_hour, alarm_min}, {1'b1, 5'd6, 6'd0});
    chk("timeout_no_load", n_load, 2);

    // one-cycle reset while editing minutes
    cur_hour = 5'd10; cur_min = 6'd20;
    press(M, 2);
    press(M, 2);
    chk("midreset_in_set_min", {edit_field, edit_value}, {2'd2, 6'd20});
    rst_n = 1'b0;
    tick();
    chk("midreset_outputs", 64'(dut_vec), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      end else if (r < 8) begin
        repeat (110) tick();
      end else if (r < 18) begin
        cur_hour = 5'($urandom_range(0, 23));
        cur_min  = 6'($urandom_range(0, 59));
        tick();
      end else begin
        press(3'($urandom_range(1, 7)), $urandom_range(1, 3));
        repeat ($urandom_range(0, 2)) tick();
      end
    end

`ifdef ALARM_SET_AUTOREPEAT_EN
    mdl_on = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    cur_hour = 5'd0; cur_min = 6'd0;
    tick();
    press(M, 2);
    btn_inc = 1'b1; repeat (30) tick(); btn_inc = 1'b0; repeat (4) tick();
    chk("autorepeat_inc", edit_value, 6'd6);
    btn_inc = 1'b1; btn_dec = 1'b1; repeat (30) tick();
    btn_inc = 1'b0; btn_dec = 1'b0; repeat (4) tick();
    chk("autorepeat_both_held", edit_value, 6'd6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
